// File: rtl/event_encoder_8to3.sv
// Sequential 8-to-3 event encoder: captures event strobes into a pending set and
// presents their indices one at a time, in priority order, over valid/ready.
module event_encoder_8to3 #(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] evt,
    output logic [2:0] code,
    output logic       valid,
    input  logic       ready,
    output logic [7:0] pending,
    output logic       ovf,
    input  logic       ovf_clr
);

    typedef enum logic {ST_IDLE = 1'b0, ST_PRESENT = 1'b1} state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_pending;
    logic [2:0] r_code;
    logic       r_ovf;

    logic [7:0] w_cap;
    logic [7:0] w_clr;
    logic [7:0] w_rem;
    logic [7:0] w_pending_nxt;
    logic       w_accept;
    logic       w_ovf_set;
    logic       w_ovf_nxt;
    logic [2:0] w_code_nxt;

    // Later matches overwrite earlier ones, so the scan direction sets the priority.
    function automatic logic [2:0] enc(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (LSB_FIRST) begin
                if (v[7-i]) idx = 3'(7 - i);
            end else begin
                if (v[i]) idx = 3'(i);
            end
        end
        return idx;
    endfunction

    assign w_cap         = en ? 8'h00 : evt;
    assign w_accept      = (r_state == ST_PRESENT) && ready;
    assign w_clr         = w_accept ? (8'h01 << r_code) : 8'h00;
    assign w_rem         = r_pending & ~w_clr;
    assign w_pending_nxt = w_rem | w_cap;
    // A re-event on the bit being retired this cycle simply re-pends it.
    assign w_ovf_set     = |(w_cap & w_rem);
    assign w_ovf_nxt     = w_ovf_set ? 1'b1 : (ovf_clr ? 1'b0 : r_ovf);

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_pending <= 8'h00;
            r_code    <= 3'd0;
            r_ovf     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
            r_code    <= w_code_nxt;
            r_ovf     <= w_ovf_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (r_pending != 8'h00) w_state_nxt = ST_PRESENT;
                else                    w_state_nxt = ST_IDLE;
            end
            ST_PRESENT: begin
                if (w_accept && (w_rem == 8'h00)) w_state_nxt = ST_IDLE;
                else                              w_state_nxt = ST_PRESENT;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Next code: held while waiting on the consumer, no preemption.
    always_comb begin
        w_code_nxt = r_code;
        case (r_state)
            ST_IDLE: begin
                if (r_pending != 8'h00) w_code_nxt = enc(r_pending);
                else                    w_code_nxt = r_code;
            end
            ST_PRESENT: begin
                if (w_accept && (w_rem != 8'h00)) w_code_nxt = enc(w_rem);
                else                              w_code_nxt = r_code;
            end
            default: w_code_nxt = r_code;
        endcase
    end

    assign code    = r_code;
    assign valid   = (r_state == ST_PRESENT);
    assign pending = r_pending;
    assign ovf     = r_ovf;

endmodule

// File: doc/event_encoder_8to3.md
Name: event_encoder_8to3

Overview:
- Sequential 8-to-3 encoder; the inverse of our 3-to-8 decoder.
- Captures event strobes on eight lines into a pending register.
- Emits the 3-bit index of each pending event, one at a time, in priority order over a valid/ready handshake.
- Sits between event sources (decoded select lines, interrupt-style strobes) and a consumer that needs a compact binary code.
- Uses the decoder's active-low enable convention.

Parameters:
- LSB_FIRST, 1, priority order: 1 = index 0 highest priority; 0 = index 7 highest priority.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- en  input  1  capture enable, active-low; 0 = capture events, 1 = ignore new events (draining continues)
- evt  input  8  event strobes; bit i = event i, multi-hot allowed
- code  output  3  index of presented event; code[0] is LSB (weight of input a on the decoder)
- valid  output  1  code is valid
- ready  input  1  consumer accepts code when valid & ready
- pending  output  8  currently pending events (registered)
- ovf  output  1  sticky overflow flag
- ovf_clr  input  1  clears ovf

Behaviour:
- Reset (rst=1 at a clock edge): pending=8'h00, code=3'd0, valid=0, ovf=0, state=IDLE. Reset overrides every other input, including mid-handshake; a presented code is dropped and not re-presented.
- Capture:
  - cap = (en==0) ? evt : 8'h00.
  - clr = one-hot(code) when valid & ready, else 8'h00.
  - Update: pending <= (pending & ~clr) | cap.
- Overflow: ovf <= 1 if any bit has cap[i]=1 while pending[i]=1 and clr[i]=0.
  - Re-event on the bit being cleared that cycle re-pends it with no overflow.
  - ovf_clr=1 clears ovf. If set and clear occur in the same cycle, set wins.
- Encode function enc(v):
  - LSB_FIRST=1: lowest set index.
  - LSB_FIRST=0: highest set index.
- States:
  - IDLE (valid=0): if pending!=0, then code<=enc(pending), valid<=1, go to PRESENT. Otherwise stay.
  - PRESENT (valid=1): code and valid are held stable while ready=0, even if a higher-priority event arrives (no preemption). On valid & ready, compute rem = pending & ~clr:
    - rem!=0: code<=enc(rem), valid stays 1, stay in PRESENT (back-to-back, one code per cycle).
    - rem==0: valid<=0, go to IDLE. Events captured in that same cycle are presented from IDLE on the following cycle.
- Latency: event at edge t → pending set after edge t → valid after edge t+1 (2 cycles from an idle start).
- Throughput: 1 code/cycle while pending codes remain and ready=1.
- en=1 blocks capture only; already-pending events still drain normally.
- evt=8'h00 with pending empty: outputs stay idle, no state change.
- code is meaningful only when valid=1. It holds its last value when valid=0 (3'd0 after reset).

Test Plan:
1. Reset, then en=0, evt=8'b0000_0100 for 1 cycle, ready=1 → valid=1 with code=3'd2 two cycles after the strobe; pending clears to 8'h00 after acceptance; valid drops next cycle.
2. evt=8'b1000_0011 single cycle, ready=1, LSB_FIRST=1 → codes 0,1,7 on consecutive cycles, then valid=0. With LSB_FIRST=0 → order 7,1,0.
3. Backpressure: pending 8'b0010_0000, ready=0 for 5 cycles, and evt=8'b0000_0001 arrives mid-wait → code stays 3'd5 throughout; after ready=1, code 5 is accepted, then code 0 is presented.
4. Overflow: evt bit 3 twice while code 3 is not accepted → ovf=1 and stays set; ovf_clr=1 → ovf=0. A re-event on bit 3 in the same cycle code 3 is accepted → ovf stays 0, code 3 is presented again.
5. en=1 with evt=8'hFF → pending stays 8'h00, valid=0. With pending=8'h06 and en=1 → codes 1 then 2 still drain.
6. Reset mid-operation: pending=8'hF0, valid=1, assert rst 1 cycle → next cycle pending=8'h00, valid=0, code=0, ovf=0; no stale codes afterwards.
